// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch front end.
// Issues one word read per cycle to a 1-cycle-latency instruction memory,
// buffers returned {pc, instr} pairs in a 2-entry FIFO and presents the head
// to decode. Redirects flush everything buffered or in flight.
//
// Output handshake: an instruction transfers to decode in a cycle where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0,
// out_instr/out_pc hold their value.
module instr_fetch #(
    parameter int ADDR_WIDTH  = 9,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic [ADDR_WIDTH-1:0]  pc_next,
    output logic                   imem_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc
);

    // FIFO is a two-slot shift structure: slot 0 is the head and drives the
    // outputs straight from flops; slot 1 is the second entry.
    logic [1:0]             count_q, count_d;
    logic                   inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
    logic [ADDR_WIDTH-1:0]  head_pc_q, head_pc_d;
    logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d;
    logic [ADDR_WIDTH-1:0]  tail_pc_q, tail_pc_d;
    logic [INSTR_WIDTH-1:0] tail_instr_q, tail_instr_d;

    logic       pop;
    logic       push;
    logic       issue;
    logic [1:0] occupancy;

    // Issue decision, PC steering and memory request.
    always_comb begin
        pop       = (count_q != 2'd0) & out_ready;
        push      = inflight_q & ~redirect_valid & ~rst;
        // Entries that will exist after this edge without a new issue; pop
        // implies count_q >= 1 so this never underflows.
        occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue     = ~rst & ~redirect_valid & (occupancy < 2'd2);

        imem_addr = pc;
        imem_en   = issue;
        if (rst) begin
            pc_next = '0;
        end else if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (issue) begin
            pc_next = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            pc_next = pc;
        end
    end

    // Next-state for the FIFO and the in-flight tracker.
    always_comb begin
        count_d       = count_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_pc_d     = head_pc_q;
        head_instr_d  = head_instr_q;
        tail_pc_d     = tail_pc_q;
        tail_instr_d  = tail_instr_q;

        if (rst) begin
            count_d      = 2'd0;
            inflight_d   = 1'b0;
            head_pc_d    = '0;
            head_instr_d = '0;
        end else if (redirect_valid) begin
            // A head popped this cycle has already been taken by decode;
            // everything else is dropped.
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = pc;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d    = inflight_pc_q;
                        head_instr_d = imem_rdata;
                    end else begin
                        tail_pc_d    = inflight_pc_q;
                        tail_instr_d = imem_rdata;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    count_d      = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_pc_d    = inflight_pc_q;
                        head_instr_d = imem_rdata;
                    end else begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = inflight_pc_q;
                        tail_instr_d = imem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        count_q       <= count_d;
        inflight_q    <= inflight_d;
        inflight_pc_q <= inflight_pc_d;
        head_pc_q     <= head_pc_d;
        head_instr_q  <= head_instr_d;
        tail_pc_q     <= tail_pc_d;
        tail_instr_q  <= tail_instr_d;
    end

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = head_pc_q;
    assign out_instr = head_instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. The bench supplies the PC
// register (pc <= pc_next) and a 1-cycle memory returning 0x1000+addr.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  pc = '0;
  logic [8:0]  pc_next;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [8:0]  redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [8:0]  out_pc;

  int n_checks = 0;
  int n_pass = 0;

  // clock / environment
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pc <= pc_next;
    if (imem_en) imem_rdata <= 32'h1000 + {23'b0, imem_addr};
  end

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  // advance one cycle; inputs are then driven, checks follow at +2
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    step(); step(); settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_pc !== 9'h0) $display("FAIL reset_pc got %h exp 0", out_pc); else n_pass++;
    n_checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", out_instr); else n_pass++;
    n_checks++; if (imem_en !== 1'b0) $display("FAIL reset_en got %0b exp 0", imem_en); else n_pass++;
    n_checks++; if (pc_next !== 9'h0) $display("FAIL reset_pc_next got %h exp 0", pc_next); else n_pass++;
  endtask

  // cycle 0 is the first cycle with rst low
  task automatic test_startup();
    step(); rst = 1'b0; settle();
    n_checks++; if (imem_en !== 1'b1 || imem_addr !== 9'h0 || pc_next !== 9'h1)
      $display("FAIL start_issue got en=%0b addr=%h nxt=%h exp 1/000/001", imem_en, imem_addr, pc_next); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL start_cyc1_valid got %0b exp 0", out_valid); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h0 || out_instr !== 32'h1000)
      $display("FAIL start_first got v=%0b pc=%h i=%h exp 1/000/00001000", out_valid, out_pc, out_instr); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      step(); settle();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'(k) || out_instr !== 32'h1000 + k)
        $display("FAIL start_stream got v=%0b pc=%h i=%h exp pc=%h", out_valid, out_pc, out_instr, 9'(k)); else n_pass++;
    end
  endtask

  // head is pc 5, one fetch in flight
  task automatic test_backpressure();
    out_ready = 1'b0; settle();
    n_checks++; if (imem_en !== 1'b0) $display("FAIL bp_en_first got %0b exp 0", imem_en); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      step(); settle();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h5 || out_instr !== 32'h1005 || imem_en !== 1'b0)
        $display("FAIL bp_hold got v=%0b pc=%h i=%h en=%0b exp 1/005/00001005/0", out_valid, out_pc, out_instr, imem_en); else n_pass++;
    end
    step(); out_ready = 1'b1; settle();
    for (int k = 5; k <= 10; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'(k) || out_instr !== 32'h1000 + k)
        $display("FAIL bp_release got v=%0b pc=%h exp pc=%h", out_valid, out_pc, 9'(k)); else n_pass++;
      step(); settle();
    end
  endtask

  // entry: head pc 11 shown, count 1, pc 12 in flight
  task automatic test_redirect();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 9'h040; settle();
    n_checks++; if (pc_next !== 9'h040 || imem_en !== 1'b0)
      $display("FAIL redir_cycle got nxt=%h en=%0b exp 040/0", pc_next, imem_en); else n_pass++;
    step(); redirect_valid = 1'b0; out_ready = 1'b1; settle();
    n_checks++; if (out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 9'h040)
      $display("FAIL redir_after got v=%0b en=%0b addr=%h exp 0/1/040", out_valid, imem_en, imem_addr); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL redir_stale got v=%0b pc=%h exp 0", out_valid, out_pc); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h040 || out_instr !== 32'h1040)
      $display("FAIL redir_target got v=%0b pc=%h i=%h exp 1/040/00001040", out_valid, out_pc, out_instr); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h041)
      $display("FAIL redir_next got v=%0b pc=%h exp 1/041", out_valid, out_pc); else n_pass++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 9'h1FE;
    step(); redirect_valid = 1'b0; settle();
    step(); settle();
    n_checks++; if (imem_addr !== 9'h1FF || imem_en !== 1'b1 || pc_next !== 9'h000)
      $display("FAIL wrap_issue got addr=%h en=%0b nxt=%h exp 1ff/1/000", imem_addr, imem_en, pc_next); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h1FE)
      $display("FAIL wrap_1fe got v=%0b pc=%h exp 1/1fe", out_valid, out_pc); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h1FF || out_instr !== 32'h11FF)
      $display("FAIL wrap_1ff got v=%0b pc=%h i=%h exp 1/1ff/000011ff", out_valid, out_pc, out_instr); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h000 || out_instr !== 32'h1000)
      $display("FAIL wrap_000 got v=%0b pc=%h i=%h exp 1/000/00001000", out_valid, out_pc, out_instr); else n_pass++;
  endtask

  // entry: head pc 0, count 1, pc 1 in flight
  task automatic test_reset_midop();
    rst = 1'b1; settle();
    n_checks++; if (pc_next !== 9'h0 || imem_en !== 1'b0)
      $display("FAIL rst_mid_cycle got nxt=%h en=%0b exp 000/0", pc_next, imem_en); else n_pass++;
    step(); rst = 1'b0; settle();
    n_checks++; if (out_valid !== 1'b0 || out_pc !== 9'h0 || out_instr !== 32'h0)
      $display("FAIL rst_mid_after got v=%0b pc=%h i=%h exp 0/000/0", out_valid, out_pc, out_instr); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_inflight got v=%0b pc=%h exp 0", out_valid, out_pc); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h0 || out_instr !== 32'h1000)
      $display("FAIL rst_mid_first got v=%0b pc=%h i=%h exp 1/000/00001000", out_valid, out_pc, out_instr); else n_pass++;
  endtask

  // entry: head pc 0, count 1, pc 1 in flight
  task automatic test_redirect_pop();
    out_ready = 1'b0;
    step(); settle();
    step(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 9'h0A0; settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h0 || out_instr !== 32'h1000)
      $display("FAIL rp_head got v=%0b pc=%h exp 1/000", out_valid, out_pc); else n_pass++;
    step(); redirect_valid = 1'b0; settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rp_flush got v=%0b pc=%h exp 0", out_valid, out_pc); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rp_flush2 got v=%0b pc=%h exp 0", out_valid, out_pc); else n_pass++;
    step(); settle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h0A0 || out_instr !== 32'h10A0)
      $display("FAIL rp_target got v=%0b pc=%h i=%h exp 1/0a0/000010a0", out_valid, out_pc, out_instr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midop();
    test_redirect_pop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
